// File: rtl/des_key_sched.sv
// Round-robin arbiter sharing one DES subkey generator between N_REQ requesters.
// The generator is reloaded only when the winner's key/mode differs from the loaded context.
module des_key_sched #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [64*N_REQ-1:0] req_key,
    input  logic [N_REQ-1:0]    req_encrypt,
    input  logic [N_REQ-1:0]    release_i,  // "release" is a reserved word
    output logic [N_REQ-1:0]    gnt,
    output logic                gnt_parity_err,
    output logic                busy,
    output logic                timeout_err,
    output logic                gen_key_en,
    output logic [63:0]         gen_key,
    output logic                gen_encrypt,
    input  logic                gen_valid,
    input  logic                gen_parity_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_DROP, WAIT_VALID, GRANT} state_e;

    state_e         state_q;
    logic [IW-1:0]  rr_q, win_q;
    logic [CW-1:0]  cnt_q;
    logic [63:0]    ctx_key_q, gen_key_q;
    logic           ctx_enc_q, ctx_valid_q, par_q;
    logic [N_REQ-1:0] gnt_q;
    logic           gnt_perr_q, timeout_err_q, gen_key_en_q, gen_encrypt_q;

    logic [IW-1:0]  win_d, cand;
    logic           found;
    int unsigned    idx;
    logic [63:0]    sel_key;
    logic           sel_enc, hit, timeout_hit;

    // First requester searching upward from rr+1, wrapping.
    always_comb begin
        found = 1'b0;
        win_d = rr_q;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx  = (int'(rr_q) + k) % N_REQ;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win_d = cand;
            end
        end
    end

    assign sel_key     = req_key[{win_d, 6'd0} +: 64];
    assign sel_enc     = req_encrypt[win_d];
    assign hit         = ctx_valid_q && gen_valid && (sel_key == ctx_key_q) && (sel_enc == ctx_enc_q);
    assign timeout_hit = (cnt_q >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_q          <= IW'(N_REQ - 1);
            win_q         <= '0;
            cnt_q         <= '0;
            ctx_key_q     <= '0;
            ctx_enc_q     <= 1'b0;
            ctx_valid_q   <= 1'b0;
            par_q         <= 1'b0;
            gnt_q         <= '0;
            gnt_perr_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            gen_key_en_q  <= 1'b0;
            gen_key_q     <= '0;
            gen_encrypt_q <= 1'b0;
        end else begin
            gen_key_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        rr_q  <= win_d;
                        win_q <= win_d;
                        if (hit) begin
                            state_q    <= GRANT;
                            gnt_q      <= ONE << win_d;
                            gnt_perr_q <= par_q;
                        end else begin
                            state_q       <= LOAD;
                            ctx_valid_q   <= 1'b0;
                            gen_key_en_q  <= 1'b1;
                            gen_key_q     <= sel_key;
                            gen_encrypt_q <= sel_enc;
                            ctx_key_q     <= sel_key;
                            ctx_enc_q     <= sel_enc;
                        end
                    end
                end
                LOAD: begin
                    state_q <= WAIT_DROP;
                    cnt_q   <= '0;
                end
                WAIT_DROP: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!gen_valid) begin
                        state_q <= WAIT_VALID;
                    end else if (timeout_hit) begin
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                        ctx_valid_q   <= 1'b0;
                    end
                end
                WAIT_VALID: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (gen_valid) begin
                        ctx_valid_q <= 1'b1;
                        par_q       <= gen_parity_err;
                        if (req[win_q]) begin
                            state_q    <= GRANT;
                            gnt_q      <= ONE << win_q;
                            gnt_perr_q <= gen_parity_err;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                        ctx_valid_q   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_i[win_q] || !req[win_q]) begin
                        state_q    <= IDLE;
                        gnt_q      <= '0;
                        gnt_perr_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt            = gnt_q;
    assign gnt_parity_err = gnt_perr_q;
    assign busy           = (state_q != IDLE);
    assign timeout_err    = timeout_err_q;
    assign gen_key_en     = gen_key_en_q;
    assign gen_key        = gen_key_q;
    assign gen_encrypt    = gen_encrypt_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched with a behavioural subkey-generator stand-in
// (valid drops 2 cycles after key_en, returns ~18 cycles later, odd-parity check per byte).
module tb_des_key_sched;

    localparam int TO = 31;
    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY_PE = 64'h133457799BBCDFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, enc, rel;
    logic [63:0] k0, k1;
    logic [1:0]  gnt;
    logic        gnt_parity_err, busy, timeout_err, gen_key_en, gen_encrypt;
    logic [63:0] gen_key;
    logic        gen_valid, gen_parity_err;

    int tests = 0;
    int fails = 0;

    des_key_sched #(.N_REQ(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_key({k1, k0}), .req_encrypt(enc),
        .release_i(rel), .gnt(gnt), .gnt_parity_err(gnt_parity_err), .busy(busy),
        .timeout_err(timeout_err), .gen_key_en(gen_key_en), .gen_key(gen_key),
        .gen_encrypt(gen_encrypt), .gen_valid(gen_valid), .gen_parity_err(gen_parity_err)
    );

    always #5 clk = ~clk;

    // Generator stand-in
    logic        gv_q, gpe_q, force_v;
    int unsigned gc;
    logic [63:0] gk;

    function automatic logic par_bad(input logic [63:0] k);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 8; i++) if (^k[8*i +: 8] == 1'b0) b = 1'b1;
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            gv_q <= 1'b0; gpe_q <= 1'b0; gc <= 0; gk <= '0;
        end else if (gen_key_en) begin
            gc <= 1; gk <= gen_key;
        end else if (gc != 0) begin
            if (gc == 1) gv_q <= 1'b0;
            if (gc == 18) begin
                gv_q <= 1'b1; gpe_q <= par_bad(gk); gc <= 0;
            end else gc <= gc + 1;
        end
    end
    assign gen_valid      = force_v | gv_q;
    assign gen_parity_err = gpe_q;

    // Load-pulse and one-hot monitors
    int          ken_cnt = 0;
    int          gnt_multi = 0;
    logic [63:0] ken_key;
    logic        ken_enc;
    always @(negedge clk) begin
        if (gen_key_en) begin
            ken_cnt <= ken_cnt + 1; ken_key <= gen_key; ken_enc <= gen_encrypt;
        end
        if (gnt == 2'b11) gnt_multi <= gnt_multi + 1;
    end

    task automatic wait_gnt(input int max, output int cyc, output int rise);
        logic prev;
        prev = gen_valid; cyc = -1; rise = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (gen_valid && !prev && rise < 0) rise = i;
            prev = gen_valid;
            if (gnt != 2'b00) begin cyc = i; break; end
        end
    endtask

    task automatic drop_all(input logic [1:0] r);
        rel = r; req = 2'b00;
        @(negedge clk);
        rel = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; enc = '0; rel = '0; k0 = '0; k1 = '0; force_v = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt got %b want 00", gnt); end
        tests++; if ({busy, timeout_err, gnt_parity_err, gen_key_en, gen_encrypt} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b want 00000", {busy, timeout_err, gnt_parity_err, gen_key_en, gen_encrypt}); end
        tests++; if (gen_key !== 64'h0) begin fails++; $display("FAIL reset_key got %h want 0", gen_key); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_grant;
        int c0, cyc, rise;
        c0 = ken_cnt; k0 = KEY_A; enc = 2'b01; req = 2'b01;
        wait_gnt(80, cyc, rise);
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL load_gnt got %b want 01", gnt); end
        tests++; if (cyc < 0 || rise < 0 || cyc - rise != 1) begin fails++; $display("FAIL load_gnt_latency got %0d want 1", cyc - rise); end
        tests++; if (gnt_parity_err !== 1'b0) begin fails++; $display("FAIL load_perr got %b want 0", gnt_parity_err); end
        tests++; if (ken_cnt - c0 != 1) begin fails++; $display("FAIL load_pulses got %0d want 1", ken_cnt - c0); end
        tests++; if (ken_key !== KEY_A || ken_enc !== 1'b1) begin fails++; $display("FAIL load_key got %h/%b want %h/1", ken_key, ken_enc, KEY_A); end
        rel = 2'b01; req = 2'b00;
        @(negedge clk);
        rel = 2'b00;
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL release_gnt got %b want 00", gnt); end
    endtask

    task automatic test_hit;
        int c0;
        c0 = ken_cnt; req = 2'b01;
        @(negedge clk);
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL hit_gnt got %b want 01", gnt); end
        repeat (2) @(negedge clk);
        tests++; if (ken_cnt != c0) begin fails++; $display("FAIL hit_no_reload got %0d pulses want 0", ken_cnt - c0); end
        drop_all(2'b01);
    endtask

    task automatic test_mode_change;
        int c0, bad, seen;
        c0 = ken_cnt; bad = 0; seen = 0; enc = 2'b00; req = 2'b01;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (gen_key_en) seen = 1;
            if (seen != 0 && gen_encrypt !== 1'b0) bad++;
            if (gnt != 2'b00) break;
        end
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL mode_gnt got %b want 01", gnt); end
        tests++; if (ken_cnt - c0 != 1) begin fails++; $display("FAIL mode_reload got %0d pulses want 1", ken_cnt - c0); end
        tests++; if (bad != 0 || ken_enc !== 1'b0) begin fails++; $display("FAIL mode_enc_stable got %0d glitches enc %b want 0/0", bad, ken_enc); end
        drop_all(2'b01);
    endtask

    task automatic test_back_to_back;
        int c0, cyc, rise;
        logic [1:0] want [3];
        // rr points at 0 after the previous grants, so index 1 wins first
        want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10;
        k0 = KEY_A; k1 = KEY_B; enc = 2'b11; req = 2'b11;
        for (int n = 0; n < 3; n++) begin
            c0 = ken_cnt;
            wait_gnt(80, cyc, rise);
            tests++; if (gnt !== want[n]) begin fails++; $display("FAIL rr_gnt%0d got %b want %b", n, gnt, want[n]); end
            tests++; if (ken_cnt - c0 != 1) begin fails++; $display("FAIL rr_reload%0d got %0d want 1", n, ken_cnt - c0); end
            rel = gnt;
            if (n == 2) req = 2'b00;
            @(negedge clk);
            rel = 2'b00;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int i, gbad, seen;
        gbad = 0; seen = 0; force_v = 1'b1; req = 2'b11;
        i = 0;
        while (i < 60 && timeout_err !== 1'b1) begin
            @(negedge clk); i++;
            if (gnt != 2'b00) gbad++;
        end
        tests++; if (i != TO + 2) begin fails++; $display("FAIL timeout_cycles got %0d want %0d", i, TO + 2); end
        tests++; if (gbad != 0) begin fails++; $display("FAIL timeout_no_gnt got %0d grant cycles want 0", gbad); end
        for (int j = 0; j < 5 && seen == 0; j++) begin
            @(negedge clk);
            if (gen_key_en) begin
                seen = 1;
                tests++; if (gen_key !== KEY_B) begin fails++; $display("FAIL timeout_next_key got %h want %h", gen_key, KEY_B); end
            end
        end
        tests++; if (seen != 1) begin fails++; $display("FAIL timeout_next_load got %0d want 1", seen); end
        force_v = 1'b0; req = 2'b10;
        wait_gnt(80, i, gbad);
        tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL timeout_next_gnt got %b want 10", gnt); end
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky got %b want 1", timeout_err); end
        drop_all(2'b10);
    endtask

    task automatic test_parity;
        int cyc, rise;
        k0 = KEY_PE; enc = 2'b01; req = 2'b01;
        wait_gnt(80, cyc, rise);
        tests++; if ({gnt, gnt_parity_err} !== 3'b011) begin fails++; $display("FAIL parity_gnt got %b/%b want 01/1", gnt, gnt_parity_err); end
        drop_all(2'b01);
        tests++; if (gnt_parity_err !== 1'b0) begin fails++; $display("FAIL parity_idle got %b want 0", gnt_parity_err); end
        req = 2'b01;
        @(negedge clk);
        tests++; if ({gnt, gnt_parity_err} !== 3'b011) begin fails++; $display("FAIL parity_hit got %b/%b want 01/1", gnt, gnt_parity_err); end
        drop_all(2'b01);
    endtask

    task automatic test_reset_midload;
        int c0, cyc, rise, seen;
        seen = 0; k0 = KEY_A; enc = 2'b01; req = 2'b01;
        for (int j = 0; j < 5 && seen == 0; j++) begin
            @(negedge clk);
            if (gen_key_en) seen = 1;
        end
        repeat (6) @(negedge clk);
        tests++; if ({busy, gen_valid, gnt} !== 4'b1000) begin fails++; $display("FAIL midload_state got %b want 1000", {busy, gen_valid, gnt}); end
        rst = 1'b1; req = 2'b00;
        @(negedge clk);
        tests++; if ({gnt, busy, timeout_err, gnt_parity_err, gen_key_en, gen_encrypt} !== 7'b0) begin
            fails++; $display("FAIL midload_rst got %b want 0000000", {gnt, busy, timeout_err, gnt_parity_err, gen_key_en, gen_encrypt}); end
        tests++; if (gen_key !== 64'h0) begin fails++; $display("FAIL midload_rst_key got %h want 0", gen_key); end
        rst = 1'b0;
        @(negedge clk);
        c0 = ken_cnt; req = 2'b01;
        wait_gnt(80, cyc, rise);
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL midload_regnt got %b want 01", gnt); end
        tests++; if (ken_cnt - c0 != 1) begin fails++; $display("FAIL midload_reload got %0d want 1", ken_cnt - c0); end
        drop_all(2'b01);
    endtask

    initial begin
        test_reset;
        test_load_grant;
        test_hit;
        test_mode_change;
        test_back_to_back;
        test_timeout;
        test_parity;
        test_reset_midload;
        tests++; if (gnt_multi != 0) begin fails++; $display("FAIL gnt_onehot got %0d cycles with 11 want 0", gnt_multi); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
